mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
// - Shares the single synchronous-read data RAM port between the core's instruction-fetch requester (I) and its load/store requester (D).
// - Sits between the core pipeline and the ram instance; the core drives req/gnt/rvalid handshakes instead of driving RAM pins directly.
// - One outstanding transaction at a time; 1-cycle RAM read latency is absorbed here.
// PARAMETERS
// - AW  32  address width; addresses are word indices, passed to RAM unchanged (no shift, no wrap logic)
// - DW  32  data width; byte-enable width is DW/8
// PORTS
// - clk        in   1     clock, all state on posedge
// - rst_n      in   1     asynchronous, active-low reset
// - i_req      in   1     fetch request; held with i_addr until i_gnt
// - i_addr     in   AW    fetch word address
// - i_gnt      out  1     1-cycle pulse: I request accepted and issued to RAM
// - i_rvalid   out  1     1-cycle pulse: i_rdata valid
// - i_rdata    out  DW    fetch data
// - d_req      in   1     load/store request; held with d_* until d_gnt
// - d_we       in   DW/8  byte write enables; 0 = read
// - d_addr     in   AW    data word address
// - d_wdata    in   DW    store data
// - d_gnt      out  1     1-cycle pulse: D request accepted and issued
// - d_rvalid   out  1     1-cycle pulse: read data valid / write completed
// - d_rdata    out  DW    load data; 0 on write completion
// - ram_we     out  DW/8  byte write enables to RAM
// - ram_addr   out  AW    RAM address
// - ram_wdata  out  DW    RAM write data
// - ram_rdata  in   DW    RAM read data, valid one cycle after the address is presented
// BEHAVIOUR
// - States: IDLE, ISSUE, RESP. owner reg (I/D) records the winner.
// - IDLE: if any req, pick winner, register addr/we/wdata to ram_*, -> ISSUE; else stay.
// - ISSUE (1 cycle): ram_* driven; winner's gnt=1; -> RESP. ram_we nonzero only in ISSUE.
// - RESP (1 cycle): winner's rvalid=1, rdata=ram_rdata (read) or 0 (write); ram_we=0.
//   If any req pending (excluding the just-served request, whose req is still seen high only if renewed), pick and -> ISSUE; else -> IDLE.
// - Latency: req sampled at edge N -> gnt in cycle N+1 -> rvalid in cycle N+2. Back-to-back throughput: 1 transaction per 2 cycles.
// - Arbitration (default): fixed priority, D beats I on simultaneous req.
// - Requester dropping req before gnt is a protocol violation; the arbiter samples req only in IDLE/RESP and serves whatever was sampled.
// - Loser's gnt/rvalid stay 0; its request stays pending and is served next decision point.
// - Reset (async, any state): state=IDLE, owner=I, all gnt/rvalid=0, ram_we=0, ram_addr=0, ram_wdata=0, i_rdata=d_rdata=0; in-flight transaction dropped, no rvalid, no RAM write after rst_n falls.
// - gnt and rvalid are registered outputs; never both high for the same requester in one cycle.
// CONFIGURATION
// - ARB_ROUND_ROBIN_EN undefined: fixed priority D > I (I may starve under continuous D traffic).
// - ARB_ROUND_ROBIN_EN defined: on simultaneous req, winner = requester not served last (last_owner reg, reset to D so I wins first tie); single req always wins.
// STRUCTURE
// - Shared header bus.vh: state encodings (ST_IDLE/ST_ISSUE/ST_RESP), owner encodings (OWN_I/OWN_D), width macros next to `WORD in config.vh.
// - One sub-module: arb_pick (combinational: i_req, d_req, last_owner -> winner, any); holds the macro-dependent policy.
// - Top: FSM, owner/last_owner regs, ram_* output regs, response steering.
// TESTING
// - Reset mid-ISSUE of a D write (d_we=4'hF) -> ram_we=0 immediately, no d_rvalid, state IDLE after release.
// - Single I read addr 0x10, ram returns 0xDEADBEEF -> i_gnt at N+1, i_rvalid with i_rdata=0xDEADBEEF at N+2.
// - Simultaneous i_req/d_req (d read 0x20) -> default: d served first, i next (gnt 2 cycles later); with RR_EN: i first, then d.
// - D store d_we=4'b0011 addr 0x5 data 0x1234ABCD -> ram_we=0011 one cycle only, d_rvalid with d_rdata=0.
// - Continuous d_req for 10 transactions with i_req high -> default: i_gnt never asserted; RR_EN: i/d grants alternate.
// - Random back-to-back traffic vs reference model -> every gnt followed by exactly one rvalid next cycle, data matches RAM model.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for mem_port_arbiter: FSM state encoding and requester identities.
package mem_port_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_RESP  = 2'd2
   } state_t;

   typedef enum logic {
      OWN_I = 1'b0,
      OWN_D = 1'b1
   } owner_t;

   function automatic owner_t other_owner(input owner_t o);
      return (o == OWN_I) ? OWN_D : OWN_I;
   endfunction

endpackage

// File: rtl/mem_port_arbiter_arb_pick.sv
// Combinational winner selection between fetch (I) and load/store (D) requests.
// Policy: fixed D > I by default; ARB_ROUND_ROBIN_EN alternates on ties.
module mem_port_arbiter_arb_pick
   import mem_port_arbiter_pkg::*;
(
   input  logic   i_req,
   input  logic   d_req,
   input  owner_t last_owner,
   output owner_t winner,
   output logic   any
);

   assign any = i_req | d_req;

`ifdef ARB_ROUND_ROBIN_EN
   // On a tie the requester that was not served last wins.
   always_comb begin
      winner = OWN_I;
      if (i_req && d_req) begin
         winner = other_owner(last_owner);
      end else if (d_req) begin
         winner = OWN_D;
      end
   end
`else
   logic unused_last_owner;
   assign unused_last_owner = last_owner;
   assign winner = d_req ? OWN_D : OWN_I;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous-read RAM port between fetch (I) and load/store (D) requesters.
// Arbitration policy selected by ARB_ROUND_ROBIN_EN (undefined: fixed D > I).
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int AW = 32,
   parameter int DW = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            i_req,
   input  logic [AW-1:0]   i_addr,
   output logic            i_gnt,
   output logic            i_rvalid,
   output logic [DW-1:0]   i_rdata,
   input  logic            d_req,
   input  logic [DW/8-1:0] d_we,
   input  logic [AW-1:0]   d_addr,
   input  logic [DW-1:0]   d_wdata,
   output logic            d_gnt,
   output logic            d_rvalid,
   output logic [DW-1:0]   d_rdata,
   output logic [DW/8-1:0] ram_we,
   output logic [AW-1:0]   ram_addr,
   output logic [DW-1:0]   ram_wdata,
   input  logic [DW-1:0]   ram_rdata
);

   state_t state, state_nxt;
   owner_t owner, last_owner, winner;
   logic   any;
   logic   take;
   logic   is_write;

   mem_port_arbiter_arb_pick u_pick (
      .i_req      (i_req),
      .d_req      (d_req),
      .last_owner (last_owner),
      .winner     (winner),
      .any        (any)
   );

   // Requests are only sampled at decision points: IDLE and the RESP cycle.
   always_comb begin
      state_nxt = state;
      take      = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (any) begin
               take      = 1'b1;
               state_nxt = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            state_nxt = ST_RESP;
         end
         ST_RESP: begin
            if (any) begin
               take      = 1'b1;
               state_nxt = ST_ISSUE;
            end else begin
               state_nxt = ST_IDLE;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // ram_we is cleared every cycle unless a new transaction is issued, so a
   // write strobe lasts exactly the ISSUE cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         owner      <= OWN_I;
         last_owner <= OWN_D;
         is_write   <= 1'b0;
         i_gnt      <= 1'b0;
         d_gnt      <= 1'b0;
         i_rvalid   <= 1'b0;
         d_rvalid   <= 1'b0;
         ram_we     <= '0;
         ram_addr   <= '0;
         ram_wdata  <= '0;
      end else begin
         i_gnt    <= take && (winner == OWN_I);
         d_gnt    <= take && (winner == OWN_D);
         i_rvalid <= (state == ST_ISSUE) && (owner == OWN_I);
         d_rvalid <= (state == ST_ISSUE) && (owner == OWN_D);
         ram_we   <= '0;
         if (take) begin
            owner      <= winner;
            last_owner <= winner;
            if (winner == OWN_D) begin
               ram_addr  <= d_addr;
               ram_we    <= d_we;
               ram_wdata <= d_wdata;
               is_write  <= |d_we;
            end else begin
               ram_addr  <= i_addr;
               ram_wdata <= '0;
               is_write  <= 1'b0;
            end
         end
      end
   end

   // RAM read data arrives during RESP; steer it straight to the owner.
   assign i_rdata = (state == ST_RESP && owner == OWN_I) ? ram_rdata : '0;
   assign d_rdata = (state == ST_RESP && owner == OWN_D && !is_write) ? ram_rdata : '0;

endmodule
